// File: rtl/tinker_mem_pkg.sv
// Shared definitions for the Tinker memory arbiter.
// Contents:
//   state_t      - arbiter FSM states (IDLE, WAIT, RESP)
//   owner_t      - which requester owns the in-flight transaction
//   MEM_BYTES    - size of the Tinker memory in bytes
//   DATA_W/INSN_W- memory data width and instruction width
//   lat_preload  - latency counter load value for a given memory latency
package tinker_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_t;

    localparam int unsigned MEM_BYTES = 524288;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned INSN_W    = 32;

    // The WAIT state counts down to zero, so a latency of N loads N-1.
    // Latencies 1..4 fit in two bits (4 wraps to 3 as intended).
    function automatic logic [1:0] lat_preload(input int unsigned lat);
        logic [31:0] lat_v;
        lat_v = lat;
        return lat_v[1:0] - 2'd1;
    endfunction

endpackage

// File: rtl/tinker_mem_arbiter_if.sv
// Bus bundle between the pipeline/memory side and the arbiter.
// Groups the fetch port (if_*), the data port (d_*) and the memory
// port (mem_*).
//   slave  : the arbiter's view (requests in, grants/responses/commands out)
//   master : the environment's view (pipeline stages and memory)
interface tinker_mem_arbiter_if
    import tinker_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [INSN_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/tinker_starve_ctr.sv
// Saturating counter used to track consecutive arbitration losses.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   inc        - count one loss (saturates at MAX)
//   clr        - clear the count (wins over inc)
//   at_max     - registered flag, high while the count equals MAX
module tinker_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          at_max_r;

    // Next count: clear has priority, increment stops at MAX.
    always_comb begin
        cnt_s = cnt_r;
        if (clr) begin
            cnt_s = CW'(0);
        end else if (inc && (cnt_r != CW'(MAX))) begin
            cnt_s = cnt_r + CW'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Count register; at_max is derived from the next count so it tracks cnt_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= CW'(0);
            at_max_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_s;
            at_max_r <= (cnt_s == CW'(MAX));
        end
    end

    assign at_max = at_max_r;

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Arbiter sharing the single Tinker memory port between instruction fetch
// (32-bit reads) and the MEM stage (64-bit loads/stores). One transaction is
// in flight at a time; data wins ties unless fetch has lost STARVE_MAX times
// in a row.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   bus        - fetch, data and memory signals (tinker_mem_arbiter_if.slave)
//   busy       - a transaction is in flight (FSM not in IDLE)
// Grants and the memory command are combinational in IDLE; responses and
// rdata come from registers.
module tinker_mem_arbiter
    import tinker_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    tinker_mem_arbiter_if.slave  bus,
    output logic                 busy
);

    state_t              state_r;
    state_t              state_s;
    owner_t              owner_r;
    owner_t              owner_s;
    logic                store_r;
    logic                store_s;
    logic [1:0]          lat_r;
    logic [1:0]          lat_s;
    logic                sample_s;

    logic                fetch_win_s;
    logic                data_win_s;
    logic                if_gnt_s;
    logic                d_gnt_s;
    logic                mem_en_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_s;

    logic                starve_at_max_s;
    logic                starve_inc_s;
    logic                starve_clr_s;

    logic [INSN_W-1:0]   if_rdata_r;
    logic [DATA_W-1:0]   d_rdata_r;
    logic                if_rvalid_r;
    logic                d_rvalid_r;
    logic                busy_r;

    // Next-state, arbitration and memory command; everything is held at 0 under reset.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        store_s     = store_r;
        lat_s       = lat_r;
        sample_s    = 1'b0;
        fetch_win_s = 1'b0;
        data_win_s  = 1'b0;
        if_gnt_s    = 1'b0;
        d_gnt_s     = 1'b0;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        if (reset) begin
            state_s = IDLE;
            owner_s = NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    fetch_win_s = bus.if_req & (~bus.d_req | starve_at_max_s);
                    data_win_s  = bus.d_req & ~fetch_win_s;
                    if (fetch_win_s) begin
                        if_gnt_s   = 1'b1;
                        mem_en_s   = 1'b1;
                        mem_addr_s = bus.if_addr;
                        state_s    = WAIT;
                        lat_s      = lat_preload(MEM_LAT);
                        owner_s    = FETCH;
                        store_s    = 1'b0;
                    end else if (data_win_s) begin
                        d_gnt_s     = 1'b1;
                        mem_en_s    = 1'b1;
                        mem_we_s    = bus.d_we;
                        mem_addr_s  = bus.d_addr;
                        mem_wdata_s = bus.d_wdata;
                        state_s     = WAIT;
                        lat_s       = lat_preload(MEM_LAT);
                        owner_s     = DATA;
                        store_s     = bus.d_we;
                    end else begin
                        owner_s = NONE;
                    end
                end
                WAIT: begin
                    // mem_rdata is valid in the cycle the countdown reaches zero.
                    if (lat_r == 2'd0) begin
                        sample_s = 1'b1;
                        state_s  = RESP;
                    end else begin
                        lat_s = lat_r - 2'd1;
                    end
                end
                RESP: begin
                    state_s = IDLE;
                    owner_s = NONE;
                end
                default: begin
                    state_s = IDLE;
                    owner_s = NONE;
                end
            endcase
        end
    end

    // Fetch loses a contested IDLE arbitration -> count; any fetch grant or idle fetch -> clear.
    assign starve_inc_s = bus.if_req & data_win_s;
    assign starve_clr_s = ~bus.if_req | if_gnt_s;

    tinker_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (starve_inc_s),
        .clr    (starve_clr_s),
        .at_max (starve_at_max_s)
    );

    // FSM state, transaction bookkeeping and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_r     <= NONE;
            store_r     <= 1'b0;
            lat_r       <= 2'd0;
            if_rdata_r  <= {INSN_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            store_r     <= store_s;
            lat_r       <= lat_s;
            if_rvalid_r <= (state_s == RESP) && (owner_s == FETCH);
            d_rvalid_r  <= (state_s == RESP) && (owner_s == DATA);
            busy_r      <= (state_s != IDLE);
            if (sample_s) begin
                if (owner_r == FETCH) begin
                    if_rdata_r <= bus.mem_rdata[INSN_W-1:0];
                end else if (store_r) begin
                    d_rdata_r <= {DATA_W{1'b0}};
                end else begin
                    d_rdata_r <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_gnt    = if_gnt_s;
    assign bus.if_rvalid = if_rvalid_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_gnt     = d_gnt_s;
    assign bus.d_rvalid  = d_rvalid_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.mem_en    = mem_en_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign busy          = busy_r;

endmodule

// File: doc/tinker_mem_arbiter.md
Name: tinker_mem_arbiter

Overview:
- Shares the single Tinker memory port (524288-byte, little-endian, 64-bit data) between two requesters: the instruction-fetch stage (32-bit reads) and the MEM stage (64-bit load/store, including call/return stack traffic).
- Sits between the pipeline stages and the memory.
- Allows one outstanding transaction at a time, with a fixed memory latency.
- Data requests have priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, byte address width.
- MEM_LAT, 1, memory cycles from command cycle to mem_rdata valid; legal range 1..4.
- STARVE_MAX, 4, consecutive fetch losses after which fetch wins.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- if_req  input  1  fetch request; held until granted.
- if_addr  input  ADDR_W  fetch byte address.
- if_gnt  output  1  fetch accepted this cycle.
- if_rvalid  output  1  one-cycle fetch response strobe.
- if_rdata  output  32  fetched instruction.
- d_req  input  1  data request; held until granted.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data byte address.
- d_wdata  input  64  store data.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  one-cycle load data / store acknowledge.
- d_rdata  output  64  load data; 0 on store acknowledge.
- mem_en  output  1  memory command strobe.
- mem_we  output  1  memory write.
- mem_addr  output  ADDR_W  memory byte address.
- mem_wdata  output  64  memory write data.
- mem_rdata  input  64  memory read data, valid MEM_LAT cycles after the mem_en cycle.
- busy  output  1  transaction in flight (state != IDLE).

Behaviour:
- Reset (asynchronous):
  - state = IDLE; starve count = 0; owner = NONE.
  - All outputs are 0, including if_rdata and d_rdata.
  - A reset asserted mid-transaction drops the transaction. No rvalid is produced afterward.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Arbitration is combinational.
  - Winner rules:
    - d_req alone → data.
    - if_req alone → fetch.
    - Both asserted → data, unless starve count == STARVE_MAX, in which case fetch wins.
  - In the same cycle, the winner's gnt = 1 and mem_en = 1, with mem_we/mem_addr/mem_wdata driven from the winner.
  - For fetch: mem_we = 0 and mem_wdata = 0.
  - Next state = WAIT; latency counter loads MEM_LAT-1; owner is registered.
  - No requests → stay in IDLE, all strobes 0.
- WAIT:
  - The counter decrements each cycle.
  - When the counter is 0, mem_rdata is sampled at that clock edge into the owner's rdata register, and next state = RESP.
  - mem_en = 0 throughout WAIT.
- RESP:
  - The owner's rvalid = 1 for exactly one cycle.
  - Fetch owner: if_rdata = mem_rdata[31:0].
  - Data load: d_rdata = mem_rdata.
  - Data store: d_rdata = 0.
  - Next state = IDLE. No grant is issued in RESP.
- Latency:
  - Grant cycle T: rvalid asserts in cycle T+MEM_LAT+1.
  - Minimum request-to-request spacing is MEM_LAT+2 cycles.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each IDLE arbitration where if_req = 1 and data wins.
  - Clears when fetch is granted, or whenever if_req = 0.
- Grants assert only in IDLE. A requester that drops its req before grant is not served.
- rdata registers hold their value between responses. Only the rvalid strobes are pulses.
- No alignment or range checking. Addresses pass through unchanged, since the memory handles byte lanes.
- Requests arriving during WAIT/RESP see gnt = 0 and must be held.

Decomposition:
- Shared package tinker_mem_pkg containing:
  - state enum {IDLE, WAIT, RESP}.
  - owner enum {NONE, FETCH, DATA}.
  - MEM_BYTES = 524288.
- Optional sub-module tinker_starve_ctr: saturating counter with inc/clr inputs and an at_max output, reusable for future arbiters.
- The FSM and latency counter stay in the top module.

Test Plan:
- Fetch only, MEM_LAT = 1: if_req with if_addr = 0x2000, memory holding 0x0000_0000_DEADBEEF → if_gnt in cycle 0, mem_en = 1 with mem_addr = 0x2000 in cycle 0, if_rvalid in cycle 2 with if_rdata = 0xDEADBEEF.
- Store then load, MEM_LAT = 2: store 0x1122334455667788 to 0x7FFF8 → d_rvalid in cycle 3 with d_rdata = 0. A following load from 0x7FFF8, granted in cycle 4 → d_rvalid in cycle 7 with d_rdata = 0x1122334455667788.
- Contention: if_req and d_req both held continuously, STARVE_MAX = 4 → grant order D,D,D,D,F,D,D,D,D,F. busy stays 1 except in each IDLE cycle.
- Reset mid-flight: assert reset during WAIT of a load → all outputs 0 immediately. No d_rvalid after reset is released. The next request is serviced normally.
- Idle and back-pressure: if_req raised during RESP → if_gnt = 0 in RESP, if_gnt = 1 in the following IDLE cycle.
- Sweep MEM_LAT = 1..4: rvalid always asserts exactly MEM_LAT+1 cycles after the grant.
